// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the ROM read port.
// Request/grant handshake: a port raises req with a stable addr; the cycle in
// which gnt=1 is the transfer cycle, and the matching rvalid/rdata/rerr appear
// exactly one cycle later. Dropping req without a grant withdraws the request.
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              f_rerr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rerr;
  logic              rom_enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, f_flush, d_req, d_addr, rom_inst,
    output f_gnt, f_rvalid, f_rdata, f_rerr,
    output d_gnt, d_rvalid, d_rdata, d_rerr,
    output rom_enable, rom_addr
  );

  // Requester/ROM side.
  modport master (
    output f_req, f_addr, f_flush, d_req, d_addr, rom_inst,
    input  f_gnt, f_rvalid, f_rdata, f_rerr,
    input  d_gnt, d_rvalid, d_rdata, d_rerr,
    input  rom_enable, rom_addr
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the single combinational instruction-ROM read port between the fetch
// port (F) and the memory-stage table-load port (D). D has fixed priority; F is
// forced through after STARVE_MAX consecutive denied cycles. Responses are
// registered and return one cycle after the grant.
module rom_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  rom_port_arbiter_if.slave   bus,
  output logic [3:0]          dbg_starve_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       f_win;
  logic       d_win;

  // Arbitration: starved F first, then D, then F; nothing while in reset.
  always_comb begin
    f_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      if (bus.f_req && (starve_cnt == STARVE_LIM)) begin
        f_win = 1'b1;
      end else if (bus.d_req) begin
        d_win = 1'b1;
      end else if (bus.f_req) begin
        f_win = 1'b1;
      end
    end
  end

  assign bus.f_gnt      = f_win;
  assign bus.d_gnt      = d_win;
  assign bus.rom_enable = f_win | d_win;
  assign bus.rom_addr   = f_win ? bus.f_addr :
                          d_win ? bus.d_addr : {ADDR_W{1'b0}};
  assign dbg_starve_cnt = starve_cnt;

  // Starvation counter: counts consecutive denied F requests, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (bus.f_req && !f_win) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Fetch response register; a flush kills rvalid but the access still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.f_rvalid <= 1'b0;
      bus.f_rerr   <= 1'b0;
      bus.f_rdata  <= {DATA_W{1'b0}};
    end else begin
      bus.f_rvalid <= f_win && !bus.f_flush;
      bus.f_rerr   <= f_win && bus.f_addr[0];
      if (f_win) begin
        bus.f_rdata <= bus.rom_inst;
      end
    end
  end

  // Data-load response register; misaligned addresses still return the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.d_rvalid <= 1'b0;
      bus.d_rerr   <= 1'b0;
      bus.d_rdata  <= {DATA_W{1'b0}};
    end else begin
      bus.d_rvalid <= d_win;
      bus.d_rerr   <= d_win && bus.d_addr[0];
      if (d_win) begin
        bus.d_rdata <= bus.rom_inst;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed steps followed by randomized traffic,
// each cycle compared against a behavioural reference model.
module tb_rom_port_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [3:0] dbg_starve_cnt;

  rom_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ROM contents, indexed by word address (byte address >> 1).
  logic [DATA_W-1:0] rom_mem [256];
  assign bus.rom_inst = rom_mem[bus.rom_addr[8:1]];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int                m_deny    = 0;
  logic              e_frv     = 1'b0;
  logic [DATA_W-1:0] e_frd     = '0;
  logic              e_fre     = 1'b0;
  logic              frd_known = 1'b1;
  logic              fre_known = 1'b1;
  logic              e_drv     = 1'b0;
  logic [DATA_W-1:0] e_drd     = '0;
  logic              e_dre     = 1'b0;
  logic              obs_f_gnt = 1'b0;
  logic              obs_d_gnt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle of stimulus with grant-cycle and response checks.
  task automatic step(input logic r, input logic fr, input logic [15:0] fa,
                      input logic ff, input logic dr, input logic [15:0] da);
    logic ef, ed;
    logic [15:0] ea;
    @(negedge clk);
    rst         = r;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.f_flush = ff;
    bus.d_req   = dr;
    bus.d_addr  = da;
    #1;
    // F wins when it has waited STARVE_MAX denied cycles or D is idle.
    ef = !r && fr && ((m_deny >= STARVE_MAX) || !dr);
    ed = !r && dr && !ef;
    ea = ef ? fa : (ed ? da : 16'h0000);
    obs_f_gnt = bus.f_gnt;
    obs_d_gnt = bus.d_gnt;
    chk("f_gnt", 32'(bus.f_gnt), 32'(ef));
    chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
    chk("rom_enable", 32'(bus.rom_enable), 32'(ef | ed));
    chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
    @(posedge clk);
    if (r) begin
      m_deny = 0;
      e_frv = 1'b0; e_frd = '0; e_fre = 1'b0; frd_known = 1'b1; fre_known = 1'b1;
      e_drv = 1'b0; e_drd = '0; e_dre = 1'b0;
    end else begin
      if (fr && !ef) m_deny = (m_deny + 1 > STARVE_MAX) ? STARVE_MAX : m_deny + 1;
      else           m_deny = 0;
      e_frv = ef && !ff;
      e_fre = ef && fa[0];
      fre_known = !(ef && ff);
      if (ef) begin
        if (ff) frd_known = 1'b0;
        else begin
          frd_known = 1'b1;
          e_frd = rom_mem[fa[8:1]];
        end
      end
      e_drv = ed;
      e_dre = ed && da[0];
      if (ed) e_drd = rom_mem[da[8:1]];
    end
    #1;
    chk("f_rvalid", 32'(bus.f_rvalid), 32'(e_frv));
    if (fre_known) chk("f_rerr", 32'(bus.f_rerr), 32'(e_fre));
    if (frd_known) chk("f_rdata", 32'(bus.f_rdata), 32'(e_frd));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_drv));
    chk("d_rerr", 32'(bus.d_rerr), 32'(e_dre));
    chk("d_rdata", 32'(bus.d_rdata), 32'(e_drd));
    chk("starve_cnt", 32'(dbg_starve_cnt), 32'(m_deny));
  endtask

  initial begin
    logic [15:0] fa;
    logic        fr;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom);
    rom_mem[2] = 16'hA5A5;
    rom_mem[3] = 16'h3C3C;
    rom_mem[8] = 16'h8181;
    bus.f_req = 1'b0; bus.f_addr = '0; bus.f_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_addr = '0;

    // Reset with both requesting: no grants.
    step(1, 1, 16'h0004, 0, 1, 16'h0010);
    step(1, 1, 16'h0004, 0, 1, 16'h0010);
    // First cycle out of reset: D wins, previous-cycle responses are idle.
    step(0, 1, 16'h0004, 0, 1, 16'h0010);
    chk("first_gnt_d", 32'(obs_d_gnt), 32'd1);
    step(0, 1, 16'h0004, 0, 0, 16'h0000);

    // Single fetch of word[2].
    step(0, 1, 16'h0004, 0, 0, 16'h0000);
    chk("fetch_data", 32'(bus.f_rdata), 32'h0000A5A5);
    step(0, 0, 16'h0000, 0, 0, 16'h0000);

    // Conflict: D wins, F follows once D drops.
    step(0, 1, 16'h0004, 0, 1, 16'h0010);
    chk("conflict_d_data", 32'(bus.d_rdata), 32'h00008181);
    step(0, 1, 16'h0004, 0, 0, 16'h0000);
    chk("conflict_f_gnt", 32'(obs_f_gnt), 32'd1);

    // Starvation: D,D,D,D,F repeating.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 16'h0004, 0, 1, 16'h0010);
      chk("starve_pattern", 32'(obs_f_gnt), 32'((i % 5) == 4));
    end
    step(0, 0, 16'h0000, 0, 0, 16'h0000);

    // Flush kills the response; the next fetch returns normally.
    step(0, 1, 16'h0004, 1, 0, 16'h0000);
    chk("flush_rvalid", 32'(bus.f_rvalid), 32'd0);
    step(0, 1, 16'h0006, 0, 0, 16'h0000);
    chk("after_flush_rvalid", 32'(bus.f_rvalid), 32'd1);

    // Misaligned D then aligned D.
    step(0, 0, 16'h0000, 0, 1, 16'h0007);
    chk("misaligned_rerr", 32'(bus.d_rerr), 32'd1);
    chk("misaligned_data", 32'(bus.d_rdata), 32'h00003C3C);
    step(0, 0, 16'h0000, 0, 1, 16'h0006);
    chk("aligned_rerr", 32'(bus.d_rerr), 32'd0);

    // Randomized traffic; F keeps its address stable while pending.
    fa = 16'($urandom_range(0, 511));
    fr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!fr || obs_f_gnt) fa = 16'($urandom_range(0, 511));
      fr = ($urandom_range(0, 9) < 7);
      step(($urandom_range(0, 59) == 0), fr, fa, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) < 6), 16'($urandom_range(0, 511)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters: the instruction-fetch stage (port F) and a memory-stage constant/table-load path (port D).
- Arbitration is fixed-priority in favour of D, with a starvation guard for F.
- Responses are registered, so every granted request returns data exactly one cycle after grant.
- Sits between the IF/MEM stages and the ROM; it is the only driver of the ROM enable and address inputs.

Parameters:
- ADDR_W, 16, byte-address width of both request ports and the ROM address.
- DATA_W, 16, instruction/data word width.
- STARVE_MAX, 4, consecutive cycles F may be denied while requesting before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held with f_addr stable until f_gnt.
- f_addr  in  ADDR_W  fetch byte address.
- f_flush  in  1  fetch flush (branch taken); cancels the response of a same-cycle fetch grant.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch response valid (registered).
- f_rdata  out  DATA_W  fetch response word (registered).
- f_rerr  out  1  fetch response misaligned (registered; qualifies f_rvalid).
- d_req  in  1  data-load request.
- d_addr  in  ADDR_W  data byte address.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  data response valid (registered).
- d_rdata  out  DATA_W  data response word (registered).
- d_rerr  out  1  data response misaligned (registered).
- rom_enable  out  1  ROM chip enable; 1 only in cycles with a grant.
- rom_addr  out  ADDR_W  address of the granted request, else 0.
- rom_inst  in  DATA_W  ROM read data (combinational from rom_addr).

Behaviour:
- Reset (rst=1 at an edge):
  - f_rvalid, d_rvalid, f_rerr and d_rerr clear to 0; f_rdata and d_rdata clear to 0; starve_cnt clears to 0.
  - While rst=1, f_gnt, d_gnt and rom_enable are 0 and rom_addr is 0.
  - Reset mid-operation discards any response due the following cycle.
- At most one grant per cycle. Total throughput is one access per cycle, and back-to-back grants to the same port are allowed.
- Arbitration in cycle N:
  - if starve_cnt == STARVE_MAX and f_req: grant F;
  - else if d_req: grant D;
  - else if f_req: grant F;
  - else no grant.
- On grant in cycle N:
  - the granted port's gnt=1, rom_enable=1, rom_addr=granted addr;
  - at the edge ending N, rom_inst is captured into that port's rdata;
  - that port's rvalid=1 in N+1;
  - that port's rerr = addr[0] of the request (the word is still returned).
- Any port without a grant in N has rvalid=0 in N+1; its rdata holds its previous value.
- starve_cnt (4 bits):
  - at each edge: if f_req && !f_gnt then increment, saturating at STARVE_MAX; else 0.
  - A forced F grant therefore occurs after exactly STARVE_MAX denied cycles; the count then restarts.
- f_flush:
  - If f_flush=1 in a cycle where F is granted, f_rvalid=0 in N+1; the ROM access still occurs and f_rdata may update.
  - f_flush never affects arbitration, starve_cnt, or port D.
- A requester may drop req after gnt. Deasserting req without a grant is legal and withdraws the request.
- rom_inst is never sampled in non-grant cycles.

Test Plan:
- Reset: assert rst for 2 cycles with f_req=d_req=1 -> f_gnt=d_gnt=rom_enable=0, rom_addr=0, and all rvalid=0 in the cycle after rst falls. The first grant goes to D.
- Single fetch: f_req=1, f_addr=0x0004 for one cycle, ROM word[2]=0xA5A5 -> f_gnt=1 and rom_addr=0x0004 that cycle; next cycle f_rvalid=1, f_rdata=0xA5A5, f_rerr=0.
- Conflict: f_req=d_req=1 with d_addr=0x0010 -> d_gnt=1, f_gnt=0. d_rvalid is high the next cycle with word[8]; F is granted the following cycle once d_req drops.
- Starvation: d_req and f_req held high continuously, STARVE_MAX=4 -> grants D,D,D,D,F,D,D,D,D,F,... with f_rvalid pulsing every 5th cycle.
- Flush: f_req=1 with f_flush=1 in the grant cycle -> f_gnt=1, rom_enable=1, and f_rvalid=0 next cycle. The next unflushed fetch returns f_rvalid=1.
- Misaligned: d_addr=0x0007 -> d_rvalid=1, d_rerr=1, d_rdata=word[3]. An aligned request in the following cycle returns d_rerr=0.
